ray_frame_sequencer: RTL and testbench
======================================

# ray_frame_sequencer

Per-frame scheduler for the raycasting datapath. On each accepted new-frame pulse it takes a snapshot of the player state from the controller and issues one ray request per screen column into the DDA-in stream, under a credit limit. It counts retired columns coming back from the transformation stage and requests a frame-buffer swap at the next video last-pixel once every column has retired. It sits between the controller, the ray-calculation/DDA-in FIFO, the transformation stage and the frame buffer.

## Interface
Parameters:
- NUM_COLS, 320: columns issued per frame.
- COL_W, 9: width of the column index; 2^COL_W ≥ NUM_COLS.
- MAX_INFLIGHT, 16: maximum issued-but-unretired columns (DDA FIFO headroom).
- STATE_W, 16: width of each player-state word.

Ports (one clock; reset is asynchronous and active-low):
- pixel_clk_in  in  1  system clock; all logic on rising edge.
- rst_n_in  in  1  asynchronous active-low reset.
- frame_start_in  in  1  one-cycle new-frame pulse.
- posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in  in  STATE_W each  live controller state.
- posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out  out  STATE_W each  per-frame snapshot.
- ray_tvalid_out  out  1  ray request valid.
- ray_tready_in  in  1  downstream ready.
- ray_col_out  out  COL_W  column index of the current request.
- ray_tlast_out  out  1  high with column NUM_COLS-1.
- col_retire_in  in  1  one-cycle pulse per column fully written by the transformation stage.
- video_last_pixel_in  in  1  last screen pixel pulse from video_sig_gen.
- buf_swap_out  out  1  one-cycle frame-buffer swap pulse.
- busy_out  out  1  high whenever the state is not IDLE.
- overrun_out  out  1  sticky flag: a frame start was dropped.
- retire_err_out  out  1  sticky flag: a retire arrived while inflight==0.
- skip_count_out  out  8  dropped-frame count (see Configuration).

## Operation
States:
- IDLE: on frame_start_in, latch all six *_in words into the *_out words, set col=0, go to ISSUE.
- ISSUE:
  - ray_tvalid_out = (inflight < MAX_INFLIGHT).
  - On handshake (tvalid & tready): col++ and inflight++.
  - The handshake with col==NUM_COLS-1 (tlast=1) moves the state to DRAIN.
- DRAIN: when inflight==0, go to WAIT_SWAP.
- WAIT_SWAP: on video_last_pixel_in, go to IDLE and pulse buf_swap_out on the next cycle.

Handshake rules:
- Once ray_tvalid_out is high, it and ray_col_out/ray_tlast_out hold until the handshake.
- Credit cannot shrink while a request waits, because inflight only rises on a handshake.

Inflight counter:
- Width is clog2(MAX_INFLIGHT+1).
- Handshake and retire in the same cycle leave it unchanged.
- A retire with inflight==0 is ignored and sets retire_err_out.
- Retires are honoured in every state.

Snapshot outputs change only on frame acceptance in IDLE.

Frame starts outside IDLE:
- frame_start_in in any state other than IDLE is dropped and sets overrun_out.
- frame_start_in coinciding with video_last_pixel_in in WAIT_SWAP is also dropped and counted as an overrun.

Sticky flags are cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, col=0, inflight=0. Every output is 0: snapshots, tvalid, col, tlast, buf_swap, busy, overrun, retire_err, skip_count.
- Reset mid-frame aborts immediately with no swap; the downstream FIFOs are flushed by their own reset.
- frame_start_in accepted at cycle t: snapshot valid, busy_out=1 and ray_tvalid_out=1 at t+1.
- Maximum issue rate is one column per cycle while ready and credit allow.
- Last retire at t: WAIT_SWAP at t+1 at the earliest.
- video_last_pixel_in sampled at t in WAIT_SWAP: buf_swap_out=1 at t+1 and busy_out=0 at t+1.
- Every output is registered; there are no combinational input-to-output paths.

## Configuration
- RAY_SEQ_SKIP_COUNT_EN defined: skip_count_out is an 8-bit saturating counter (stops at 255) incremented on each dropped frame start.
- RAY_SEQ_SKIP_COUNT_EN undefined: skip_count_out is a constant 0 and the counter is not synthesized.
- overrun_out behaves the same in both builds.

## Test plan
- Nominal frame: tready=1, each retire 3 cycles after its handshake. Required: exactly 320 handshakes with cols 0..319 in order, tlast only on 319, busy stays high until a single buf_swap_out pulse one cycle after video_last_pixel_in.
- Credit limit: tready=1, no retires. Required: exactly 16 handshakes, then tvalid=0. One retire pulse allows exactly one more handshake. A simultaneous handshake and retire keeps inflight at 16.
- Backpressure: hold tready=0 for 5 cycles while tvalid=1 at col 42. Required: col_out=42 and tvalid stay stable; the handshake completes on the first tready=1.
- Snapshot isolation: posX_in=0x1000 at frame start, changed to 0x2000 during ISSUE. Required: posX_out stays 0x1000 until the next accepted frame, then shows 0x2000.
- Overrun and error: frame_start_in during ISSUE, then a retire with inflight=0 in IDLE. Required: the frame start is ignored and the current frame completes. overrun_out=1, retire_err_out=1, and skip_count_out=1 (0 without the macro).
- Async reset mid-ISSUE at col 100: rst_n_in low between clock edges. Required: all outputs 0 before the next edge. After release a new frame restarts at col 0.

Source files
------------

// File: rtl/ray_frame_sequencer_if.sv
// Ray-request stream between the frame sequencer (master) and the DDA-in FIFO (slave).
// Valid/ready handshake; col/tlast are qualified by tvalid and hold until accepted.
interface ray_frame_sequencer_if #(
    parameter int COL_W = 9
);
    logic             ray_tvalid_out;
    logic             ray_tready_in;
    logic [COL_W-1:0] ray_col_out;
    logic             ray_tlast_out;

    modport master (
        output ray_tvalid_out,
        output ray_col_out,
        output ray_tlast_out,
        input  ray_tready_in
    );

    modport slave (
        input  ray_tvalid_out,
        input  ray_col_out,
        input  ray_tlast_out,
        output ray_tready_in
    );
endinterface

// File: rtl/ray_frame_sequencer.sv
// Per-frame ray scheduler: snapshots player state, issues NUM_COLS column requests, swaps buffers on retire.
// Latency: frame start -> first request 1 cycle; video last pixel -> swap pulse 1 cycle; all outputs registered.
// Backpressure: request holds until tready, issue gated by MAX_INFLIGHT credits; RAY_SEQ_SKIP_COUNT_EN adds dropped-frame counter.
module ray_frame_sequencer #(
    parameter int NUM_COLS     = 320,
    parameter int COL_W        = 9,
    parameter int MAX_INFLIGHT = 16,
    parameter int STATE_W      = 16
) (
    input  logic                     pixel_clk_in,
    input  logic                     rst_n_in,
    input  logic                     frame_start_in,
    input  logic [STATE_W-1:0]       posX_in,
    input  logic [STATE_W-1:0]       posY_in,
    input  logic [STATE_W-1:0]       dirX_in,
    input  logic [STATE_W-1:0]       dirY_in,
    input  logic [STATE_W-1:0]       planeX_in,
    input  logic [STATE_W-1:0]       planeY_in,
    output logic [STATE_W-1:0]       posX_out,
    output logic [STATE_W-1:0]       posY_out,
    output logic [STATE_W-1:0]       dirX_out,
    output logic [STATE_W-1:0]       dirY_out,
    output logic [STATE_W-1:0]       planeX_out,
    output logic [STATE_W-1:0]       planeY_out,
    ray_frame_sequencer_if.master    ray,
    input  logic                     col_retire_in,
    input  logic                     video_last_pixel_in,
    output logic                     buf_swap_out,
    output logic                     busy_out,
    output logic                     overrun_out,
    output logic                     retire_err_out,
    output logic [7:0]               skip_count_out
);
    localparam int               INF_W    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [INF_W-1:0] MAX_INF  = INF_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_SWAP} state_e;

    typedef struct packed {
        logic [STATE_W-1:0] pos_x;
        logic [STATE_W-1:0] pos_y;
        logic [STATE_W-1:0] dir_x;
        logic [STATE_W-1:0] dir_y;
        logic [STATE_W-1:0] plane_x;
        logic [STATE_W-1:0] plane_y;
    } snap_t;

    state_e           state_q, state_d;
    snap_t            snap_q, snap_d;
    logic [COL_W-1:0] col_q, col_d, col_inc;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             swap_q, swap_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             rerr_q, rerr_d;
    logic             hs, drop, retire_ok, retire_bad;

    assign hs         = tvalid_q & ray.ray_tready_in;
    assign drop       = frame_start_in & (state_q != IDLE);
    assign retire_ok  = col_retire_in & (inflight_q != '0);
    assign retire_bad = col_retire_in & (inflight_q == '0);
    assign col_inc    = col_q + COL_W'(1);

    // Credit counter sees issue and retire together so the registered tvalid tracks next-cycle credit.
    always_comb begin
        inflight_d = inflight_q;
        if (hs && !retire_ok) begin
            inflight_d = inflight_q + INF_W'(1);
        end else if (!hs && retire_ok) begin
            inflight_d = inflight_q - INF_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        col_d    = col_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        swap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start_in) begin
                    snap_d   = {posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in};
                    col_d    = '0;
                    tvalid_d = (inflight_d < MAX_INF);
                    tlast_d  = (LAST_COL == '0);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    if (tlast_q) begin
                        col_d    = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = DRAIN;
                    end else begin
                        col_d    = col_inc;
                        tlast_d  = (col_inc == LAST_COL);
                        tvalid_d = (inflight_d < MAX_INF);
                    end
                end else if (!tvalid_q) begin
                    tvalid_d = (inflight_d < MAX_INF);
                end
            end
            DRAIN: begin
                if (inflight_d == '0) begin
                    state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (video_last_pixel_in) begin
                    swap_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        overrun_d = overrun_q | drop;
        rerr_d    = rerr_q | retire_bad;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            col_q      <= '0;
            inflight_q <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            swap_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            col_q      <= col_d;
            inflight_q <= inflight_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            swap_q     <= swap_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            rerr_q     <= rerr_d;
        end
    end

`ifdef RAY_SEQ_SKIP_COUNT_EN
    logic [7:0] skip_q;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            skip_q <= 8'h00;
        end else if (drop && (skip_q != 8'hFF)) begin
            skip_q <= skip_q + 8'd1;
        end
    end

    assign skip_count_out = skip_q;
`else
    assign skip_count_out = 8'h00;
`endif

    assign ray.ray_tvalid_out = tvalid_q;
    assign ray.ray_col_out    = col_q;
    assign ray.ray_tlast_out  = tlast_q;

    assign posX_out       = snap_q.pos_x;
    assign posY_out       = snap_q.pos_y;
    assign dirX_out       = snap_q.dir_x;
    assign dirY_out       = snap_q.dir_y;
    assign planeX_out     = snap_q.plane_x;
    assign planeY_out     = snap_q.plane_y;
    assign buf_swap_out   = swap_q;
    assign busy_out       = busy_q;
    assign overrun_out    = overrun_q;
    assign retire_err_out = rerr_q;
endmodule

// File: tb/tb_ray_frame_sequencer.sv
// Randomized frames against a column/credit bookkeeping model of the sequencer.
module tb_ray_frame_sequencer;
    localparam int NC = 320;
    localparam int MI = 16;
    localparam int SW = 16;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          col_retire = 1'b0;
    logic          vlast = 1'b0;
    logic [SW-1:0] live_i [6];
    logic [SW-1:0] snap_o [6];
    logic          swap, busy, ovr, rerr;
    logic [7:0]    skip;
    int            n_tests = 0;
    int            n_fail = 0;
    int            drops = 0;
    bit            aborted;

    always #5 clk = ~clk;

    ray_frame_sequencer_if #(.COL_W(CW)) rif ();

    ray_frame_sequencer #(
        .NUM_COLS(NC), .COL_W(CW), .MAX_INFLIGHT(MI), .STATE_W(SW)
    ) dut (
        .pixel_clk_in        (clk),
        .rst_n_in            (rst_n),
        .frame_start_in      (frame_start),
        .posX_in             (live_i[0]),
        .posY_in             (live_i[1]),
        .dirX_in             (live_i[2]),
        .dirY_in             (live_i[3]),
        .planeX_in           (live_i[4]),
        .planeY_in           (live_i[5]),
        .posX_out            (snap_o[0]),
        .posY_out            (snap_o[1]),
        .dirX_out            (snap_o[2]),
        .dirY_out            (snap_o[3]),
        .planeX_out          (snap_o[4]),
        .planeY_out          (snap_o[5]),
        .ray                 (rif.master),
        .col_retire_in       (col_retire),
        .video_last_pixel_in (vlast),
        .buf_swap_out        (swap),
        .busy_out            (busy),
        .overrun_out         (ovr),
        .retire_err_out      (rerr),
        .skip_count_out      (skip)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_skip();
`ifdef RAY_SEQ_SKIP_COUNT_EN
        return (drops > 255) ? 255 : drops;
`else
        return 0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(rif.ray_tvalid_out), 32'd0);
        chk({tag, "_col"}, 32'(rif.ray_col_out), 32'd0);
        chk({tag, "_tlast"}, 32'(rif.ray_tlast_out), 32'd0);
        chk({tag, "_swap"}, 32'(swap), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_overrun"}, 32'(ovr), 32'd0);
        chk({tag, "_retire_err"}, 32'(rerr), 32'd0);
        chk({tag, "_skip"}, 32'(skip), 32'd0);
        for (int i = 0; i < 6; i++) chk({tag, "_snap"}, 32'(snap_o[i]), 32'd0);
    endtask

    // One frame: issued/retired counts define the expected column, tlast and credit-driven tvalid.
    task automatic run_frame(input int pct, input int dmin, input int dmax, input int holdoff,
                             input int stall_col, input int ovr_at, input int abort_col,
                             input bit drop_at_swap, input logic [SW-1:0] px0,
                             input logic [SW-1:0] px_mid, output bit was_aborted);
        int            issued = 0;
        int            retired = 0;
        int            k = 0;
        int            stall_left = 5;
        int            rq[$];
        bit            hs, ret, tv;
        logic [SW-1:0] es [6];
        was_aborted = 1'b0;
        for (int i = 0; i < 6; i++) live_i[i] = SW'($urandom);
        live_i[0] = px0;
        for (int i = 0; i < 6; i++) es[i] = live_i[i];
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) chk("start_snap", 32'(snap_o[i]), 32'(es[i]));
        forever begin
            if (k > 6000) begin
                chk("frame_timeout", 32'd0, 32'd1);
                break;
            end
            tv = rif.ray_tvalid_out;
            chk("tvalid", 32'(tv), 32'((issued < NC) && ((issued - retired) < MI)));
            if (tv) begin
                chk("col", 32'(rif.ray_col_out), 32'(issued));
                chk("tlast", 32'(rif.ray_tlast_out), 32'(issued == NC - 1));
            end
            chk("busy_frame", 32'(busy), 32'd1);
            chk("swap_early", 32'(swap), 32'd0);
            if (abort_col >= 0 && tv && issued == abort_col) begin
                was_aborted = 1'b1;
                return;
            end
            if (holdoff > 0 && k == holdoff) chk("credit_cap", 32'(issued), 32'(MI));
            rif.ray_tready_in = ($urandom_range(99) < pct);
            if (stall_col == issued && tv && stall_left > 0) begin
                rif.ray_tready_in = 1'b0;
                stall_left--;
            end
            ret = (k >= holdoff) && (rq.size() > 0) && (rq[0] <= k);
            col_retire = ret;
            frame_start = (k == ovr_at);
            if (k == ovr_at) drops++;
            live_i[0] = px_mid;
            for (int i = 1; i < 6; i++) live_i[i] = SW'($urandom);
            hs = tv && rif.ray_tready_in;
            tick();
            k++;
            col_retire = 1'b0;
            frame_start = 1'b0;
            if (hs) begin
                issued++;
                rq.push_back(k - 1 + $urandom_range(dmax, dmin));
            end
            if (ret) begin
                void'(rq.pop_front());
                retired++;
            end
            if (issued == NC && retired == NC) break;
        end
        rif.ray_tready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_busy", 32'(busy), 32'd1);
            chk("drain_swap", 32'(swap), 32'd0);
            chk("drain_tvalid", 32'(rif.ray_tvalid_out), 32'd0);
        end
        vlast = 1'b1;
        frame_start = drop_at_swap;
        if (drop_at_swap) drops++;
        tick();
        vlast = 1'b0;
        frame_start = 1'b0;
        chk("swap_pulse", 32'(swap), 32'd1);
        chk("swap_busy", 32'(busy), 32'd0);
        tick();
        chk("swap_single", 32'(swap), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) chk("end_snap", 32'(snap_o[i]), 32'(es[i]));
    endtask

    initial begin
        rif.ray_tready_in = 1'b0;
        for (int i = 0; i < 6; i++) live_i[i] = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        run_frame(100, 3, 3, 0, -1, -1, -1, 1'b0, 16'h1000, 16'h2000, aborted);
        chk("nominal_overrun", 32'(ovr), 32'd0);

        run_frame(100, 3, 3, 40, -1, -1, -1, 1'b0, 16'h2000, SW'($urandom), aborted);

        run_frame(70, 1, 10, 0, 42, 50, -1, 1'b0, SW'($urandom), SW'($urandom), aborted);
        chk("overrun_set", 32'(ovr), 32'd1);

        col_retire = 1'b1;
        tick();
        col_retire = 1'b0;
        chk("retire_err", 32'(rerr), 32'd1);
        chk("overrun_sticky", 32'(ovr), 32'd1);
        chk("skip_one", 32'(skip), 32'(exp_skip()));
        chk("idle_after_err", 32'(busy), 32'd0);

        run_frame(85, 1, 20, 0, -1, -1, -1, 1'b1, SW'($urandom), SW'($urandom), aborted);
        chk("skip_two", 32'(skip), 32'(exp_skip()));
        chk("retire_err_sticky", 32'(rerr), 32'd1);

        run_frame(100, 2, 6, 0, -1, -1, 100, 1'b0, SW'($urandom), SW'($urandom), aborted);
        chk("abort_reached", 32'(aborted), 32'd1);
        #1 rst_n = 1'b0;
        rif.ray_tready_in = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        check_all_zero("rst_held");
        @(negedge clk) rst_n = 1'b1;
        drops = 0;
        tick();

        run_frame(60, 1, 12, 0, -1, -1, -1, 1'b0, SW'($urandom), SW'($urandom), aborted);
        chk("restart_overrun", 32'(ovr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
